data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the memory array (power of two).
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to response (legal range 1..15).
REQ-003 Clk  input  1  single clock for the whole block; all state changes on its rising edge.
REQ-004 Rst  input  1  reset, asynchronous and active-high.
REQ-005 Req  input  1  initiator (pipeline MEM stage) request valid.
REQ-006 Write  input  1  1 = store, 0 = load; sampled with Req.
REQ-007 Size  input  2  access size: 00 word, 01 halfword, 10 byte, 11 illegal.
REQ-008 Unsigned  input  1  load only: 1 = zero-extend, 0 = sign-extend sub-word data.
REQ-009 Addr  input  32  byte address; word index = Addr[log2(DEPTH)+1:2], upper bits ignored (wrap modulo DEPTH).
REQ-010 WData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 Ready  output  1  responder can accept a request this cycle.
REQ-012 Ack  output  1  one-cycle response strobe.
REQ-013 RData  output  32  load result, valid only while Ack=1 for a load.
REQ-014 Err  output  1  misaligned or illegal-size access flag, valid only while Ack=1.

Function
REQ-015 States: IDLE, BUSY, RESP; Ready=1 only in IDLE.
REQ-016 Request accepted on a rising edge where state=IDLE and Req=1; Write, Size, Unsigned, Addr, WData latched at that edge, then ignored until the next acceptance.
REQ-017 On acceptance: state -> BUSY, internal counter loaded with LATENCY-1.
REQ-018 In BUSY: counter decrements each edge; when counter=0, state -> RESP at that edge.
REQ-019 Ack=1 for exactly the one cycle spent in RESP; state returns to IDLE on the next edge.
REQ-020 Total latency: request accepted at edge N -> Ack high in the cycle following edge N+LATENCY.
REQ-021 Req held high continuously -> next acceptance at the edge that leaves RESP's following IDLE cycle (i.e. no acceptance in BUSY or RESP); back-to-back throughput is one access per LATENCY+2 cycles.
REQ-022 Byte lanes little-endian: byte k of a word = bits [8k+7:8k], k = Addr[1:0].
REQ-023 Misaligned: halfword with Addr[0]=1, word with Addr[1:0]!=00; Size=11 always illegal.
REQ-024 Erroneous access: Err=1 with Ack, memory unchanged, RData=0.
REQ-025 Store: written at the edge entering RESP; only the addressed lane(s) change (byte: 1 lane, half: lanes Addr[1]*2..+1, word: all 4).
REQ-026 Load: memory read at the edge entering RESP; selected lane(s) shifted to [7:0]/[15:0], extended per Unsigned; word loads ignore Unsigned.
REQ-027 RData=0 and Err=0 whenever Ack=0; RData=0 during a store's Ack.
REQ-028 A store followed by a load to the same word returns the stored data (no stale read).
REQ-029 Memory array is not initialised by reset; contents persist across reset.

Reset
REQ-030 While Rst=1: state=IDLE, counter=0, Ready=1, Ack=0, RData=0, Err=0, regardless of Clk.
REQ-031 Rst asserted in BUSY or RESP aborts the access: no Ack is produced, and a pending store is not written unless its write edge preceded Rst.
REQ-032 First acceptance possible at the first rising edge after Rst deasserts with Req=1.

Verification
REQ-033 LATENCY=2: store word Addr=0x10, WData=0xDEADBEEF accepted at edge N -> Ack at cycle after N+2, Err=0; then load word 0x10 -> RData=0xDEADBEEF.
REQ-034 Store byte Addr=0x11 WData=0x000000A5 over 0x00000000, then load word 0x10 -> 0x0000A500; load byte signed 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-035 Store half Addr=0x22 WData=0x8001, load half signed 0x22 -> 0xFFFF8001; load half Addr=0x23 -> Ack with Err=1, RData=0; word 0x20 unchanged.
REQ-036 Req held high for 3 loads -> Ready low during BUSY/RESP, exactly 3 Ack pulses, spacing LATENCY+2 cycles.
REQ-037 Addr=0x400 with DEPTH=256 aliases word 0: store 0x12345678 to 0x400, load 0x0 -> 0x12345678.
REQ-038 Rst pulsed mid-BUSY of a store to 0x30 (prior 0x0) -> no Ack, Ready=1 immediately, subsequent load 0x30 -> 0x00000000.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Fixed-latency byte-addressable data memory responder for a
//               pipeline MEM stage (load/store, byte/half/word, sign control).
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Req,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [31:0] Addr,
  input  logic [31:0] WData,
  output logic        Ready,
  output logic        Ack,
  output logic [31:0] RData,
  output logic        Err
);

  localparam int         c_IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [3:0]           r_cnt;
  logic                 r_write;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic [c_IDX_W+1:0]   r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic                 r_err;
  logic [31:0]          r_mem [DEPTH];

  logic                 w_accept;
  logic                 w_fire;
  logic                 w_err;
  logic [c_IDX_W-1:0]   w_idx;
  logic [31:0]          w_word;
  logic [15:0]          w_half;
  logic [7:0]           w_byte;
  logic [31:0]          w_load;
  logic [3:0]           w_be;
  logic [31:0]          w_wlane;

  assign w_accept = (r_state == S_IDLE) && Req;
  // The access completes on the edge that moves BUSY into RESP.
  assign w_fire   = (r_state == S_BUSY) && (r_cnt == 4'd0);
  assign w_idx    = r_addr[c_IDX_W+1:2];
  assign w_word   = r_mem[w_idx];
  assign w_half   = r_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_byte   = w_word[{r_addr[1:0], 3'b000} +: 8];

  always_comb begin
    w_err = 1'b0;
    case (r_size)
      2'b00:   w_err = (r_addr[1:0] != 2'b00);
      2'b01:   w_err = r_addr[0];
      2'b10:   w_err = 1'b0;
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_load  = 32'd0;
    w_be    = 4'b0000;
    w_wlane = r_wdata;
    case (r_size)
      2'b00: begin
        w_load  = w_word;
        w_be    = 4'b1111;
      end
      2'b01: begin
        w_load  = {{16{w_half[15] & ~r_unsigned}}, w_half};
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_load  = {{24{w_byte[7] & ~r_unsigned}}, w_byte};
        w_be    = 4'b0001 << r_addr[1:0];
        w_wlane = {4{r_wdata[7:0]}};
      end
      default: begin
        w_load  = 32'd0;
        w_be    = 4'b0000;
      end
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (Req) w_next = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt      <= 4'd0;
      r_write    <= 1'b0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt      <= c_CNT_INIT;
        r_write    <= Write;
        r_size     <= Size;
        r_unsigned <= Unsigned;
        r_addr     <= Addr[c_IDX_W+1:0];
        r_wdata    <= WData;
      end else if ((r_state == S_BUSY) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Response registers hold a value only for the single RESP cycle.
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
      if (w_fire) begin
        r_err <= w_err;
        if (!w_err && !r_write) begin
          r_rdata <= w_load;
        end
      end
    end
  end

  // Array has no reset so contents survive Rst.
  always_ff @(posedge Clk) begin
    if (w_fire && r_write && !w_err) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
        end
      end
    end
  end

  assign Ready = (r_state == S_IDLE);
  assign Ack   = (r_state == S_RESP);
  assign RData = r_rdata;
  assign Err   = r_err;

endmodule
`default_nettype wire
